// File: rtl/ibex_run_ctrl_pkg.sv
// Shared types and constants for the Ibex run-control sequencer.
package ibex_run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BOOT     = 3'd1,
    RUN      = 3'd2,
    SLEEPING = 3'd3,
    DONE     = 3'd4,
    FAULT    = 3'd5
  } run_state_e;

  localparam int unsigned MINOR_CNT_W = 8;

endpackage

// File: rtl/ibex_run_ctrl_if.sv
// Probe bundle between the run/start logic (master) and the run controller (slave).
interface ibex_run_ctrl_if;
  import ibex_run_ctrl_pkg::*;

  logic                   start_i;
  logic                   core_sleep_i;
  logic                   alert_minor_i;
  logic                   alert_major_i;
  logic                   ecall_i;
  logic                   fetch_enable_o;
  logic                   debug_req_o;
  run_state_e             state_o;
  logic                   done_o;
  logic                   pass_o;
  logic                   timeout_o;
  logic [MINOR_CNT_W-1:0] minor_alert_cnt_o;

  modport master (
    output start_i, core_sleep_i, alert_minor_i, alert_major_i, ecall_i,
    input  fetch_enable_o, debug_req_o, state_o, done_o, pass_o, timeout_o,
           minor_alert_cnt_o
  );

  modport slave (
    input  start_i, core_sleep_i, alert_minor_i, alert_major_i, ecall_i,
    output fetch_enable_o, debug_req_o, state_o, done_o, pass_o, timeout_o,
           minor_alert_cnt_o
  );

endinterface

// File: rtl/ibex_run_ctrl_dbg_req_gen.sv
// Periodic debug_req pulse generator: high for the first PULSE cycles of every
// PERIOD-cycle window counted over RUN/SLEEPING cycles since the last boot.
module ibex_dbg_req_gen #(
  parameter int unsigned PERIOD = 256,
  parameter int unsigned PULSE  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_req
);

  localparam int unsigned PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PW-1:0] r_pcnt;
  logic          r_req;

  // r_pcnt is the window position of the cycle that i_run is announcing, so
  // the output registered now is the value seen during that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
      r_req  <= 1'b0;
    end else if (i_clear) begin
      r_pcnt <= '0;
      r_req  <= 1'b0;
    end else if (i_run) begin
      r_req  <= (r_pcnt < PW'(PULSE));
      r_pcnt <= (r_pcnt == PW'(PERIOD - 1)) ? '0 : r_pcnt + 1'b1;
    end else begin
      r_req  <= 1'b0;
    end
  end

  assign o_req = r_req;

endmodule

// File: rtl/ibex_run_ctrl.sv
// Ibex run-control sequencer: boot delay, run/sleep supervision, ecall end-of-test,
// fault on major alert or sleep timeout. Optional periodic debug_req under IBEX_RUN_CTRL_DBG_EN.
module ibex_run_ctrl
  import ibex_run_ctrl_pkg::*;
#(
  parameter int unsigned BOOT_DELAY    = 8,
  parameter int unsigned SLEEP_TIMEOUT = 1024,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned DBG_PERIOD    = 256,
  parameter int unsigned DBG_PULSE     = 4
) (
  input logic            clk,
  input logic            rst,
  ibex_run_ctrl_if.slave bus
);

  localparam int unsigned      BD_EFF     = (BOOT_DELAY == 0) ? 1 : BOOT_DELAY;
  localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(BD_EFF - 1);
  localparam logic [CNT_W-1:0] SLEEP_LAST = CNT_W'(SLEEP_TIMEOUT - 1);
  localparam bit               SLEEP_EN   = (SLEEP_TIMEOUT != 0);

  if (DBG_PULSE >= DBG_PERIOD) begin : g_bad_dbg
    $error("DBG_PULSE must be smaller than DBG_PERIOD");
  end

  run_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_fe;
  logic                   r_done;
  logic                   r_pass;
  logic                   r_to;
  logic [MINOR_CNT_W-1:0] r_minor;

  logic w_active;
  logic w_boot_done;
  logic w_sleep_to;

  assign w_active    = (r_state == BOOT) || (r_state == RUN) || (r_state == SLEEPING);
  assign w_boot_done = (r_state == BOOT) && (r_cnt == BOOT_LAST);
  assign w_sleep_to  = SLEEP_EN && (r_state == SLEEPING) && (r_cnt == SLEEP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_fe    <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_to    <= 1'b0;
      r_minor <= '0;
    end else begin
      case (r_state)
        IDLE, DONE, FAULT: begin
          if (bus.start_i) begin
            r_state <= BOOT;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_to    <= 1'b0;
            r_minor <= '0;
          end
        end
        BOOT: begin
          if (bus.alert_major_i) begin
            r_state <= FAULT;
            r_done  <= 1'b1;
          end else if (w_boot_done) begin
            r_state <= RUN;
            r_fe    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          if (bus.alert_major_i) begin
            r_state <= FAULT;
            r_fe    <= 1'b0;
            r_done  <= 1'b1;
          end else if (bus.ecall_i) begin
            r_state <= DONE;
            r_fe    <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (bus.core_sleep_i) begin
            r_state <= SLEEPING;
            r_cnt   <= '0;
          end
        end
        SLEEPING: begin
          // Waking up wins over a timeout that lands on the same cycle.
          if (bus.alert_major_i) begin
            r_state <= FAULT;
            r_fe    <= 1'b0;
            r_done  <= 1'b1;
          end else if (bus.ecall_i) begin
            r_state <= DONE;
            r_fe    <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= 1'b1;
          end else if (!bus.core_sleep_i) begin
            r_state <= RUN;
          end else if (w_sleep_to) begin
            r_state <= FAULT;
            r_fe    <= 1'b0;
            r_done  <= 1'b1;
            r_to    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_fe    <= 1'b0;
        end
      endcase
      // Only counts in active states, which never overlap the clear on boot entry.
      if (w_active && bus.alert_minor_i && (r_minor != '1))
        r_minor <= r_minor + 1'b1;
    end
  end

  assign bus.fetch_enable_o    = r_fe;
  assign bus.state_o           = r_state;
  assign bus.done_o            = r_done;
  assign bus.pass_o            = r_pass;
  assign bus.timeout_o         = r_to;
  assign bus.minor_alert_cnt_o = r_minor;

`ifdef IBEX_RUN_CTRL_DBG_EN
  logic w_to_boot;
  logic w_run_nxt;
  logic w_dbg_req;

  assign w_to_boot = bus.start_i &&
                     ((r_state == IDLE) || (r_state == DONE) || (r_state == FAULT));
  // Next state will be RUN or SLEEPING.
  assign w_run_nxt = !bus.alert_major_i &&
                     (w_boot_done ||
                      (((r_state == RUN) || (r_state == SLEEPING)) && !bus.ecall_i &&
                       !(w_sleep_to && bus.core_sleep_i)));

  ibex_dbg_req_gen #(
    .PERIOD (DBG_PERIOD),
    .PULSE  (DBG_PULSE)
  ) u_dbg_req_gen (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_to_boot),
    .i_run   (w_run_nxt),
    .o_req   (w_dbg_req)
  );

  assign bus.debug_req_o = w_dbg_req;
`else
  assign bus.debug_req_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_run_ctrl.sv
// Random + directed bench for ibex_run_ctrl against a cycle-count reference model.
module tb_ibex_run_ctrl;

  localparam int BD = 8;
  localparam int ST = 16;
  localparam int DP = 16;
  localparam int DW = 4;

  localparam int S_IDLE = 0, S_BOOT = 1, S_RUN = 2, S_SLEEP = 3, S_DONE = 4, S_FAULT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ibex_run_ctrl_if bus();

  ibex_run_ctrl #(
    .BOOT_DELAY    (BD),
    .SLEEP_TIMEOUT (ST),
    .CNT_W         (16),
    .DBG_PERIOD    (DP),
    .DBG_PULSE     (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: plain cycle bookkeeping.
  int m_state, m_fe, m_dbg, m_done, m_pass, m_to, m_minor;
  int m_boot_cycles, m_sleep_cycles, m_run_cycles;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE; m_fe = 0; m_dbg = 0; m_done = 0; m_pass = 0; m_to = 0; m_minor = 0;
    m_boot_cycles = 0; m_sleep_cycles = 0; m_run_cycles = 0;
  endtask

  task automatic model_step(input bit st, input bit sl, input bit mi, input bit ma, input bit ec);
    int nxt;
    bit end_fault, end_pass;
    nxt = m_state; end_fault = 0; end_pass = 0;
    if ((m_state == S_BOOT || m_state == S_RUN || m_state == S_SLEEP) && mi && m_minor < 255)
      m_minor++;
    case (m_state)
      S_IDLE, S_DONE, S_FAULT:
        if (st) begin
          nxt = S_BOOT; m_done = 0; m_pass = 0; m_to = 0; m_minor = 0;
          m_boot_cycles = 0; m_run_cycles = 0;
        end
      S_BOOT:
        if (ma) end_fault = 1;
        else begin
          m_boot_cycles++;
          if (m_boot_cycles == ((BD == 0) ? 1 : BD)) begin nxt = S_RUN; m_fe = 1; end
        end
      S_RUN:
        if (ma) end_fault = 1;
        else if (ec) end_pass = 1;
        else if (sl) begin nxt = S_SLEEP; m_sleep_cycles = 0; end
      S_SLEEP:
        if (ma) end_fault = 1;
        else if (ec) end_pass = 1;
        else if (!sl) nxt = S_RUN;
        else begin
          m_sleep_cycles++;
          if (ST != 0 && m_sleep_cycles == ST) begin end_fault = 1; m_to = 1; end
        end
      default: nxt = S_IDLE;
    endcase
    if (end_fault) begin nxt = S_FAULT; m_fe = 0; m_done = 1; end
    if (end_pass)  begin nxt = S_DONE;  m_fe = 0; m_done = 1; m_pass = 1; end
`ifdef IBEX_RUN_CTRL_DBG_EN
    if (nxt == S_RUN || nxt == S_SLEEP) begin
      m_dbg = ((m_run_cycles % DP) < DW) ? 1 : 0;
      m_run_cycles++;
    end else m_dbg = 0;
`else
    m_dbg = 0;
`endif
    m_state = nxt;
  endtask

  task automatic compare_all(input string where);
    chk({where, ".state"}, 32'(bus.state_o), m_state);
    chk({where, ".fe"},    32'(bus.fetch_enable_o), m_fe);
    chk({where, ".dbg"},   32'(bus.debug_req_o), m_dbg);
    chk({where, ".done"},  32'(bus.done_o), m_done);
    chk({where, ".pass"},  32'(bus.pass_o), m_pass);
    chk({where, ".to"},    32'(bus.timeout_o), m_to);
    chk({where, ".minor"}, 32'(bus.minor_alert_cnt_o), m_minor);
  endtask

  task automatic cyc(input string where, input bit st, input bit sl, input bit mi,
                     input bit ma, input bit ec);
    bus.start_i = st; bus.core_sleep_i = sl; bus.alert_minor_i = mi;
    bus.alert_major_i = ma; bus.ecall_i = ec;
    model_step(st, sl, mi, ma, ec);
    @(posedge clk); #1;
    compare_all(where);
  endtask

  task automatic boot_to_run(input string where);
    cyc(where, 1, 0, 0, 0, 0);
    for (int i = 0; i < BD; i++) cyc(where, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit sl;
    model_reset();
    bus.start_i = 0; bus.core_sleep_i = 0; bus.alert_minor_i = 0;
    bus.alert_major_i = 0; bus.ecall_i = 0;
    #12;
    compare_all("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Boot delay, then fetch_enable in RUN
    boot_to_run("boot");
    chk("t1_fe",    32'(bus.fetch_enable_o), 1);
    chk("t1_state", 32'(bus.state_o), S_RUN);

    // ecall ends the test with pass
    cyc("ecall", 0, 0, 0, 0, 1);
    chk("t2_state", 32'(bus.state_o), S_DONE);
    chk("t2_pass",  32'(bus.pass_o), 1);

    // Sleep timeout
    boot_to_run("slp");
    cyc("slp", 0, 0, 0, 0, 0);
    for (int i = 0; i < ST + 1; i++) cyc("slp", 0, 1, 0, 0, 0);
    chk("t3_state", 32'(bus.state_o), S_FAULT);
    chk("t3_to",    32'(bus.timeout_o), 1);
    chk("t3_pass",  32'(bus.pass_o), 0);

    // Major alert beats ecall
    boot_to_run("prio");
    cyc("prio", 0, 0, 0, 1, 1);
    chk("t4_state", 32'(bus.state_o), S_FAULT);
    chk("t4_pass",  32'(bus.pass_o), 0);
    chk("t4_to",    32'(bus.timeout_o), 0);

    // Minor alert saturation and clear on restart
    boot_to_run("minor");
    for (int i = 0; i < 300; i++) cyc("minor", 0, 0, 1, 0, 0);
    chk("t5_sat", 32'(bus.minor_alert_cnt_o), 255);
    cyc("minor", 0, 0, 0, 0, 1);
    cyc("minor", 1, 0, 0, 0, 0);
    chk("t5_clr", 32'(bus.minor_alert_cnt_o), 0);

    // Debug pulses across a few windows
    for (int i = 0; i < BD; i++) cyc("dbg", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3 * DP; i++) cyc("dbg", 0, (i % 7) > 3, 0, 0, 0);

    // Async reset while sleeping
    cyc("arst", 0, 1, 0, 0, 0);
    cyc("arst", 0, 1, 0, 0, 0);
    chk("t7_pre", 32'(bus.state_o), S_SLEEP);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("t7_fe",    32'(bus.fetch_enable_o), 0);
    chk("t7_state", 32'(bus.state_o), S_IDLE);
    compare_all("arst");
    @(posedge clk); #1 rst = 1'b0;
    compare_all("arst_rel");

    // Randomized run
    sl = 0;
    for (int i = 0; i < 4000; i++) begin
      bit st, mi, ma, ec;
      if (m_state == S_IDLE || m_state == S_DONE || m_state == S_FAULT)
        st = ($urandom_range(0, 7) == 0);
      else
        st = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 11) == 0) sl = ~sl;
      mi = ($urandom_range(0, 2) == 0);
      ma = ($urandom_range(0, 199) == 0);
      ec = ($urandom_range(0, 149) == 0);
      cyc("rand", st, sl, mi, ma, ec);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
